onchip_mem_burst_adapter: RTL and testbench

Avalon-MM burst slave placed directly upstream of the 32K x 32 single-port on-chip RAM. It accepts pipelined read and write bursts from the system interconnect and sequences them into single-word accesses on the RAM's port. The RAM's port has a fixed 1-cycle read latency. The adapter generates the waitrequest/readdatavalid handshake that the RAM itself lacks.

---
 rtl/onchip_mem_adapter_pkg.sv | 17 +
 rtl/burst_addr_gen.sv | 38 +++
 rtl/onchip_mem_burst_adapter.sv | 176 +++++++++++++++++
 tb/tb_onchip_mem_burst_adapter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_adapter_pkg.sv
// Shared types and default sizing for the on-chip RAM burst adapter.
package onchip_mem_adapter_pkg;

  // Default geometry: 32K x 32 RAM, 4-bit burstcount, bursts of up to 8 beats.
  localparam int unsigned DefAddrW   = 15;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefBurstW  = 4;
  localparam int unsigned DefMaxBurst = 8;

  // Adapter sequencing states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdBurst = 2'd1,
    StWrBurst = 2'd2
  } state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: holds the address of the current beat and the
// number of beats still owed, and presents the wrapped next address.
module burst_addr_gen #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  len_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;

  // Load a new burst, or advance one beat; load wins if both are asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      cnt_q  <= len_i;
    end else if (step_i) begin
      addr_q <= next_addr_o;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Address arithmetic is modulo 2^ADDR_W: all-ones rolls over to zero.
  assign next_addr_o = addr_q + ADDR_W'(1);
  assign last_o      = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/onchip_mem_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM with 1-cycle
// read latency. Bursts are broken into single-word RAM accesses, and the
// waitrequest/readdatavalid handshake the RAM lacks is generated here.
module onchip_mem_burst_adapter
  import onchip_mem_adapter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BURST_W   = DefBurstW,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic                clk,
  input  logic                reset,
  // Avalon-MM slave side
  input  logic [ADDR_W-1:0]   s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [BURST_W-1:0]  s_burstcount,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata,
  // Status
  output logic                burst_err
);

  localparam int unsigned BeW = DATA_W / 8;

  state_e              state_q;
  logic [ADDR_W-1:0]   m_address_q;
  logic [BeW-1:0]      m_byteenable_q;
  logic                m_chipselect_q;
  logic                m_write_q;
  logic [DATA_W-1:0]   m_writedata_q;
  logic                m_clken_q;
  logic                rdv_q;
  logic                burst_err_q;

  logic [BURST_W-1:0]  cmd_len;
  logic                cmd_illegal;
  logic                rd_accept;
  logic                wr_first;
  logic                wr_beat;
  logic                gen_load;
  logic                gen_step;
  logic [BURST_W-1:0]  gen_len;
  logic [ADDR_W-1:0]   gen_next_addr;
  logic                gen_last;

  // Clamp the requested burst length into 1..MAX_BURST and flag illegal counts.
  always_comb begin
    cmd_illegal = (s_burstcount == '0) || (s_burstcount > BURST_W'(MAX_BURST));
    if (s_burstcount == '0) begin
      cmd_len = BURST_W'(1);
    end else if (s_burstcount > BURST_W'(MAX_BURST)) begin
      cmd_len = BURST_W'(MAX_BURST);
    end else begin
      cmd_len = s_burstcount;
    end
  end

  // Only read bursts stall the slave; write beats stream at one per cycle.
  assign s_waitrequest = reset || (state_q == StRdBurst);
  assign rd_accept     = (state_q == StIdle) && s_read;
  assign wr_first      = (state_q == StIdle) && !s_read && s_write;
  assign wr_beat       = (state_q == StWrBurst) && s_write;

  // The first write beat is issued straight from the command, so the
  // generator only owes len-1 further write beats; reads count every address.
  always_comb begin
    gen_load = rd_accept || wr_first;
    gen_len  = rd_accept ? cmd_len : (cmd_len - BURST_W'(1));
    gen_step = ((state_q == StRdBurst) && !gen_last) || wr_beat;
  end

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (BURST_W)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (gen_load),
    .step_i      (gen_step),
    .base_i      (s_address),
    .len_i       (gen_len),
    .next_addr_o (gen_next_addr),
    .last_o      (gen_last)
  );

  // Sequencer: state plus every registered RAM-side and status output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      m_address_q    <= '0;
      m_byteenable_q <= '0;
      m_chipselect_q <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      m_clken_q      <= 1'b0;
      rdv_q          <= 1'b0;
      burst_err_q    <= 1'b0;
    end else begin
      m_clken_q      <= 1'b1;
      m_chipselect_q <= 1'b0;
      m_write_q      <= 1'b0;
      burst_err_q    <= 1'b0;
      // RAM data appears one cycle after a read address is presented.
      rdv_q          <= m_chipselect_q && !m_write_q;
      unique case (state_q)
        StIdle: begin
          if (s_read) begin
            state_q        <= StRdBurst;
            m_address_q    <= s_address;
            m_byteenable_q <= '1;
            m_chipselect_q <= 1'b1;
            burst_err_q    <= cmd_illegal;
          end else if (s_write) begin
            m_address_q    <= s_address;
            m_byteenable_q <= s_byteenable;
            m_writedata_q  <= s_writedata;
            m_chipselect_q <= 1'b1;
            m_write_q      <= 1'b1;
            burst_err_q    <= cmd_illegal;
            if (cmd_len > BURST_W'(1)) begin
              state_q <= StWrBurst;
            end
          end
        end
        StRdBurst: begin
          // The address on the port this cycle is the generator's current one.
          if (gen_last) begin
            state_q <= StIdle;
          end else begin
            m_address_q    <= gen_next_addr;
            m_byteenable_q <= '1;
            m_chipselect_q <= 1'b1;
          end
        end
        StWrBurst: begin
          // s_read is ignored until the write burst completes.
          if (s_write) begin
            m_address_q    <= gen_next_addr;
            m_byteenable_q <= s_byteenable;
            m_writedata_q  <= s_writedata;
            m_chipselect_q <= 1'b1;
            m_write_q      <= 1'b1;
            if (gen_last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_address       = m_address_q;
  assign m_byteenable    = m_byteenable_q;
  assign m_chipselect    = m_chipselect_q;
  assign m_write         = m_write_q;
  assign m_writedata     = m_writedata_q;
  assign m_clken         = m_clken_q;
  assign s_readdatavalid = rdv_q;
  assign s_readdata      = m_readdata;
  assign burst_err       = burst_err_q;

endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// Scoreboard bench for onchip_mem_burst_adapter with a behavioural 32K x 32 RAM.
module tb_onchip_mem_burst_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] s_address = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [3:0]  s_burstcount = '0;
  logic [3:0]  s_byteenable = '0;
  logic [31:0] s_writedata = '0;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [14:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_clken;
  logic [31:0] m_readdata = '0;
  logic        burst_err;

  always #5 clk = ~clk;

  onchip_mem_burst_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_burstcount    (s_burstcount),
    .s_byteenable    (s_byteenable),
    .s_writedata     (s_writedata),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_clken         (m_clken),
    .m_readdata      (m_readdata),
    .burst_err       (burst_err)
  );

  // Single-port RAM, 1-cycle read latency, byte-lane writes.
  logic [31:0] ram [0:32767];
  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      m_readdata <= ram[m_address];
      if (m_write) begin
        for (int b = 0; b < 4; b++) begin
          if (m_byteenable[b]) ram[m_address][8*b +: 8] = m_writedata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] rd_q[$];
  acc_t        mon_acc;
  logic [31:0] mon_rd;
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          err_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every RAM access and every read return is matched against the queues.
  always @(negedge clk) begin
    if (burst_err) err_cnt++;
    if (m_chipselect) begin
      if (acc_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_access: got addr 0x%04h we %0d, expected no access",
                 m_address, m_write);
      end else begin
        mon_acc = acc_q.pop_front();
        chk("acc_addr", 32'(m_address), 32'(mon_acc.addr));
        chk("acc_write", 32'(m_write), 32'(mon_acc.we));
        chk("acc_be", 32'(m_byteenable), 32'(mon_acc.be));
        if (mon_acc.we) chk("acc_wdata", m_writedata, mon_acc.data);
      end
    end
    if (s_readdatavalid) begin
      if (rd_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_readdata: got 0x%08h, expected no valid", s_readdata);
      end else begin
        mon_rd = rd_q.pop_front();
        chk("readdata", s_readdata, mon_rd);
      end
    end
  end

  task automatic push_acc(input logic [14:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] be);
    acc_t e;
    e.addr = a;
    e.we   = we;
    e.data = d;
    e.be   = be;
    acc_q.push_back(e);
  endtask

  task automatic exp_read(input logic [14:0] a, input logic [31:0] d);
    push_acc(a, 1'b0, 32'h0, 4'hF);
    rd_q.push_back(d);
  endtask

  // Returns #1 after the accepting edge; c is the cycle number of acceptance.
  task automatic wait_accept(output int c);
    int n = 0;
    @(negedge clk);
    while (s_waitrequest && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (s_waitrequest) begin
      total++;
      $display("FAIL accept_timeout: waitrequest stuck at 1, required 0");
    end
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_read(input logic [14:0] a, input logic [3:0] bc, output int c);
    s_read = 1'b1;
    s_write = 1'b0;
    s_address = a;
    s_burstcount = bc;
    wait_accept(c);
    s_read = 1'b0;
  endtask

  task automatic cmd_write(input logic [14:0] a, input logic [3:0] bc, input logic [31:0] d,
                           input logic [3:0] be, output int c);
    push_acc(a, 1'b1, d, be);
    s_write = 1'b1;
    s_address = a;
    s_burstcount = bc;
    s_writedata = d;
    s_byteenable = be;
    wait_accept(c);
    s_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((acc_q.size() != 0 || rd_q.size() != 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_acc", 32'(acc_q.size()), 0);
    chk("drain_rd", 32'(rd_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    int cw;
    int cr;
    logic [9:0]  rdv_pat;
    logic [9:0]  wait_pat;
    logic [14:0] t2_addr [8];
    logic [31:0] t2_data [8];

    for (int i = 0; i < 32768; i++) ram[i] = 32'h5A00_0000 | 32'(i);
    ram[16] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'(s_waitrequest), 1);
    chk("rst_chipselect", 32'(m_chipselect), 0);
    chk("rst_write", 32'(m_write), 0);
    chk("rst_clken", 32'(m_clken), 0);
    chk("rst_rdv", 32'(s_readdatavalid), 0);
    chk("rst_burst_err", 32'(burst_err), 0);
    chk("rst_address", 32'(m_address), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_waitrequest", 32'(s_waitrequest), 0);
    @(negedge clk);
    chk("rel_clken", 32'(m_clken), 1);
    @(posedge clk);
    #1;

    // 1: single read, data 2 cycles after acceptance, 1 stall cycle
    exp_read(15'h0010, 32'hDEAD_BEEF);
    cmd_read(15'h0010, 4'd1, c);
    @(negedge clk);
    chk("t1_wait_hi", 32'(s_waitrequest), 1);
    chk("t1_rdv_early", 32'(s_readdatavalid), 0);
    @(negedge clk);
    chk("t1_wait_lo", 32'(s_waitrequest), 0);
    chk("t1_rdv", 32'(s_readdatavalid), 1);
    drain();

    // 2: 8-beat read wrapping past 0x7FFF
    t2_addr = '{15'h7FFC, 15'h7FFD, 15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0002, 15'h0003};
    t2_data = '{32'h5A00_7FFC, 32'h5A00_7FFD, 32'h5A00_7FFE, 32'h5A00_7FFF,
                32'h5A00_0000, 32'h5A00_0001, 32'h5A00_0002, 32'h5A00_0003};
    for (int i = 0; i < 8; i++) exp_read(t2_addr[i], t2_data[i]);
    cmd_read(15'h7FFC, 4'd8, c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdv_pat[i]  = s_readdatavalid;
      wait_pat[i] = s_waitrequest;
    end
    chk("t2_rdv_pattern", 32'(rdv_pat), 32'h1FE);
    chk("t2_wait_pattern", 32'(wait_pat), 32'h0FF);
    drain();

    // 3: 4-beat write with a 2-cycle gap; a read strobe in the gap is ignored
    cmd_write(15'h0100, 4'd4, 32'h1111_1111, 4'hF, c);
    cmd_write(15'h0101, 4'd4, 32'h2222_2222, 4'hF, c);
    @(negedge clk);
    chk("t3_gap_wait", 32'(s_waitrequest), 0);
    @(posedge clk);
    #1 s_read = 1'b1;
    s_address = 15'h0555;
    @(negedge clk);
    chk("t3_gap_wait2", 32'(s_waitrequest), 0);
    @(posedge clk);
    #1 s_read = 1'b0;
    cmd_write(15'h0102, 4'd4, 32'h3333_3333, 4'h3, c);
    cmd_write(15'h0103, 4'd4, 32'h4444_4444, 4'hF, c);
    exp_read(15'h0100, 32'h1111_1111);
    exp_read(15'h0101, 32'h2222_2222);
    exp_read(15'h0102, 32'h5A00_3333);
    exp_read(15'h0103, 32'h4444_4444);
    cmd_read(15'h0100, 4'd4, c);
    drain();
    chk("t3_no_burst_err", 32'(err_cnt), 0);

    // 4: write then read of the same word, accepted on consecutive cycles
    cmd_write(15'h0200, 4'd1, 32'hCAFE_F00D, 4'hF, cw);
    exp_read(15'h0200, 32'hCAFE_F00D);
    cmd_read(15'h0200, 4'd1, cr);
    chk("t4_back_to_back", 32'(cr - cw), 1);
    drain();

    // 5: illegal burstcounts clamp to 1 and 8 beats, one burst_err each
    exp_read(15'h0300, 32'h5A00_0300);
    cmd_read(15'h0300, 4'd0, c);
    @(negedge clk);
    chk("t5_err_pulse", 32'(burst_err), 1);
    drain();
    chk("t5_err_cnt1", 32'(err_cnt), 1);
    for (int i = 0; i < 8; i++) exp_read(15'h0400 + 15'(i), 32'h5A00_0400 + 32'(i));
    cmd_read(15'h0400, 4'd12, c);
    drain();
    chk("t5_err_cnt2", 32'(err_cnt), 2);
    cmd_write(15'h0210, 4'd0, 32'h0BAD_F00D, 4'hF, c);
    exp_read(15'h0210, 32'h0BAD_F00D);
    cmd_read(15'h0210, 4'd1, c);
    drain();
    chk("t5_err_cnt3", 32'(err_cnt), 3);

    // 7: read wins over a simultaneous write in idle
    exp_read(15'h0220, 32'h5A00_0220);
    s_writedata = 32'hBAD0_BAD0;
    s_byteenable = 4'hF;
    s_write = 1'b1;
    cmd_read(15'h0220, 4'd1, c);
    s_write = 1'b0;
    drain();

    // 6: reset during beat 3 of an 8-beat read aborts the burst
    push_acc(15'h0500, 1'b0, 32'h0, 4'hF);
    push_acc(15'h0501, 1'b0, 32'h0, 4'hF);
    rd_q.push_back(32'h5A00_0500);
    cmd_read(15'h0500, 4'd8, c);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_wait", 32'(s_waitrequest), 1);
    chk("t6_rst_cs", 32'(m_chipselect), 0);
    chk("t6_rst_rdv", 32'(s_readdatavalid), 0);
    chk("t6_rst_clken", 32'(m_clken), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rel_wait", 32'(s_waitrequest), 0);
    chk("t6_rel_cs", 32'(m_chipselect), 0);
    chk("t6_rel_rdv", 32'(s_readdatavalid), 0);
    @(posedge clk);
    #1;
    exp_read(15'h0600, 32'h5A00_0600);
    exp_read(15'h0601, 32'h5A00_0601);
    cmd_read(15'h0600, 4'd2, c);
    drain();
    chk("t6_err_cnt", 32'(err_cnt), 3);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
